// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one signed multiplier between two requesters
//
// Purpose: accepts operations from two requesters, drives registered operands
// onto an external combinational multiplier, waits SETTLE_CYCLES, captures the
// product/overflow and holds it for the owning requester until consumed.
//
// Ports:
//   clock, reset_n                  clock, synchronous active-low reset
//   reqN_valid/ready/a/b            request handshake and signed operands (N=0,1)
//   respN_valid/ready/prod/ovf      result handshake, truncated product, overflow
//   mult_a, mult_b                  operands to the shared multiplier
//   mult_prod, mult_ovf             product and overflow from the multiplier
//   busy                            high whenever not idle
//   ovf_count                       saturating count of completed ops with overflow

module mult_share_arbiter #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int OVF_CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  output logic                 resp0_valid,
  input  logic                 resp0_ready,
  output logic [WIDTH-1:0]     resp0_prod,
  output logic                 resp0_ovf,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 resp1_valid,
  input  logic                 resp1_ready,
  output logic [WIDTH-1:0]     resp1_prod,
  output logic                 resp1_ovf,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  input  logic [WIDTH-1:0]     mult_prod,
  input  logic                 mult_ovf,
  output logic                 busy,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic                 r_prio;
  logic                 r_owner;
  logic [WIDTH-1:0]     r_op_a;
  logic [WIDTH-1:0]     r_op_b;
  logic [3:0]           r_cnt;
  logic [WIDTH-1:0]     r_prod;
  logic                 r_ovf;
  logic [OVF_CNT_W-1:0] r_ovf_count;

  logic w_any_valid;
  logic w_grant;
  logic w_accept;
  logic w_owner_ready;

  // Priority holder wins a tie; otherwise whichever requester is valid.
  assign w_any_valid   = req0_valid | req1_valid;
  assign w_grant       = r_prio ? req1_valid : ~req0_valid;
  assign w_accept      = (r_state == S_IDLE) && w_any_valid;
  assign w_owner_ready = r_owner ? resp1_ready : resp0_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_owner     <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_ovf       <= 1'b0;
      r_ovf_count <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a  <= w_grant ? req1_a : req0_a;
            r_op_b  <= w_grant ? req1_b : req0_b;
            r_owner <= w_grant;
            r_cnt   <= SETTLE_M1;
          end
        end
        S_CALC: begin
          if (r_cnt == 4'd0) begin
            r_prod <= mult_prod;
            r_ovf  <= mult_ovf;
            if (mult_ovf && (r_ovf_count != {OVF_CNT_W{1'b1}})) begin
              r_ovf_count <= r_ovf_count + OVF_CNT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (w_owner_ready) begin
            r_prio <= ~r_owner;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp0_prod  = '0;
    resp1_prod  = '0;
    resp0_ovf   = 1'b0;
    resp1_ovf   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = req0_valid && !w_grant;
        req1_ready = req1_valid && w_grant;
        if (w_accept) begin
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == 4'd0) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (r_owner) begin
          resp1_valid = 1'b1;
          resp1_prod  = r_prod;
          resp1_ovf   = r_ovf;
        end else begin
          resp0_valid = 1'b1;
          resp0_prod  = r_prod;
          resp0_ovf   = r_ovf;
        end
        if (w_owner_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operands come straight from registers so they never toggle outside an accept.
  assign mult_a    = r_op_a;
  assign mult_b    = r_op_b;
  assign busy      = (r_state != S_IDLE);
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed self-checking bench for mult_share_arbiter

module tb_mult_share_arbiter;

  logic       clock;
  logic       reset_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [3:0] resp0_prod, resp1_prod;
  logic       resp0_ovf, resp1_ovf;
  logic [3:0] mult_a, mult_b, mult_prod;
  logic       mult_ovf;
  logic       busy;
  logic [7:0] ovf_count;

  int total = 0;
  int bad   = 0;

  mult_share_arbiter #(.WIDTH(4), .SETTLE_CYCLES(1), .OVF_CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_prod(resp0_prod), .resp0_ovf(resp0_ovf),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_prod(resp1_prod), .resp1_ovf(resp1_ovf),
    .mult_a(mult_a), .mult_b(mult_b), .mult_prod(mult_prod), .mult_ovf(mult_ovf),
    .busy(busy), .ovf_count(ovf_count)
  );

  // Behavioral shared multiplier.
  logic signed [7:0] m_full;
  assign m_full    = $signed(mult_a) * $signed(mult_b);
  assign mult_prod = m_full[3:0];
  assign mult_ovf  = (m_full > 8'sd7) || (m_full < -8'sd8);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic logic rdy(input int n);
    return (n != 0) ? req1_ready : req0_ready;
  endfunction

  function automatic logic rvalid(input int n);
    return (n != 0) ? resp1_valid : resp0_valid;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Full operation on requester n; responses are consumed as soon as they appear.
  task automatic run_op(input int n, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ep, input logic eo, input string tag);
    int k;
    if (n != 0) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else        begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    k = 0;
    while (!rdy(n) && k < 20) begin tick(); k++; end
    chk({tag, "_ready"}, 32'(rdy(n)), 32'd1);
    tick();
    if (n != 0) req1_valid = 1'b0; else req0_valid = 1'b0;
    k = 0;
    while (!rvalid(n) && k < 20) begin tick(); k++; end
    chk({tag, "_valid"}, 32'(rvalid(n)), 32'd1);
    chk({tag, "_prod"}, 32'((n != 0) ? resp1_prod : resp0_prod), 32'(ep));
    chk({tag, "_ovf"}, 32'((n != 0) ? resp1_ovf : resp0_ovf), 32'(eo));
    tick();
  endtask

  initial begin
    int k;
    int p;
    logic expg;
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
    chk("rst_resp1_valid", 32'(resp1_valid), 32'd0);
    chk("rst_mult_a", 32'(mult_a), 32'd0);
    chk("rst_mult_b", 32'(mult_b), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);

    // Single op with cycle-exact latency: 3 * -2 = -6
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'hE;
    #1;
    chk("single_ready", 32'(req0_ready), 32'd1);
    chk("single_busy_idle", 32'(busy), 32'd0);
    tick();
    req0_valid = 1'b0;
    chk("single_busy_calc", 32'(busy), 32'd1);
    chk("single_valid_calc", 32'(resp0_valid), 32'd0);
    chk("single_mult_a", 32'(mult_a), 32'd3);
    chk("single_mult_b", 32'(mult_b), 32'hE);
    tick();
    chk("single_valid", 32'(resp0_valid), 32'd1);
    chk("single_prod", 32'(resp0_prod), 32'hA);
    chk("single_ovf", 32'(resp0_ovf), 32'd0);
    chk("single_busy_resp", 32'(busy), 32'd1);
    chk("single_resp1_valid", 32'(resp1_valid), 32'd0);
    chk("single_ovf_count", 32'(ovf_count), 32'd0);
    tick();
    chk("single_busy_done", 32'(busy), 32'd0);
    chk("single_valid_done", 32'(resp0_valid), 32'd0);
    chk("single_prod_zero", 32'(resp0_prod), 32'd0);

    // Overflow ops
    run_op(1, 4'd7, 4'd7, 4'h1, 1'b1, "ovf_7x7");
    chk("ovf_count1", 32'(ovf_count), 32'd1);
    run_op(1, 4'h8, 4'hF, 4'h8, 1'b1, "ovf_m8xm1");
    chk("ovf_count2", 32'(ovf_count), 32'd2);

    // Contention from reset with valids held: grants 0,1,0,1
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
    req1_valid = 1'b1; req1_a = 4'hC; req1_b = 4'd2;
    #1;
    for (int g = 0; g < 4; g++) begin
      expg = g[0];
      k = 0;
      while (!(req0_ready || req1_ready) && k < 20) begin tick(); k++; end
      chk("cont_one_hot", 32'(req0_ready & req1_ready), 32'd0);
      chk("cont_grant_ready", 32'(rdy(int'(expg))), 32'd1);
      tick();
      k = 0;
      while (!rvalid(int'(expg)) && k < 20) begin tick(); k++; end
      if (expg) begin
        chk("cont_r1_prod", 32'(resp1_prod), 32'h8);
        chk("cont_r1_ovf", 32'(resp1_ovf), 32'd0);
      end else begin
        chk("cont_r0_prod", 32'(resp0_prod), 32'h6);
        chk("cont_r0_ovf", 32'(resp0_ovf), 32'd0);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure on requester 0 while requester 1 waits
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
    #1;
    chk("bp_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(resp0_valid), 32'd1);
      chk("bp_prod", 32'(resp0_prod), 32'h6);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      chk("bp_mult_a", 32'(mult_a), 32'd2);
      chk("bp_mult_b", 32'(mult_b), 32'd3);
      tick();
    end
    resp0_ready = 1'b1;
    tick();
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_valid", 32'(resp0_valid), 32'd0);
    chk("bp_release_req1_ready", 32'(req1_ready), 32'd1);
    run_op(1, 4'd1, 4'd1, 4'h1, 1'b0, "bp_req1");

    // Reset mid-op; prio is 1 before the reset, so a tie afterwards proves prio was reset
    run_op(0, 4'd1, 4'd1, 4'h1, 1'b0, "pre_abort");
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd3;
    #1;
    chk("abort_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    chk("abort_in_calc", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_resp0_valid", 32'(resp0_valid), 32'd0);
    chk("abort_resp1_valid", 32'(resp1_valid), 32'd0);
    chk("abort_mult_a", 32'(mult_a), 32'd0);
    chk("abort_mult_b", 32'(mult_b), 32'd0);
    chk("abort_resp1_prod", 32'(resp1_prod), 32'd0);
    tick();
    tick();
    chk("abort_no_resp", 32'(resp1_valid), 32'd0);
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2;
    #1;
    chk("abort_tie_req0", 32'(req0_ready), 32'd1);
    chk("abort_tie_req1", 32'(req1_ready), 32'd0);
    run_op(0, 4'd1, 4'd2, 4'h2, 1'b0, "abort_after0");
    run_op(1, 4'd2, 4'd2, 4'h4, 1'b0, "abort_after1");

    // Exhaustive operand sweep
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        p = a * b;
        run_op(0, 4'(a), 4'(b), 4'(p), (p > 7) || (p < -8), "sweep");
      end
    end

    // Saturating overflow counter
    do_reset();
    for (int i = 0; i < 300; i++) begin
      run_op(1, 4'd7, 4'd7, 4'h1, 1'b1, "sat");
      if (i == 253) chk("sat_count_254", 32'(ovf_count), 32'd254);
    end
    chk("sat_count_final", 32'(ovf_count), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
